// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - shared types and helpers for the pipeline hazard controller
package pipeline_ctrl_pkg;

  localparam int REG_ADDR_W = 3;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    MEM_WAIT  = 2'd1,
    INT_DRAIN = 2'd2,
    INT_ACK   = 2'd3
  } state_t;

  typedef struct packed {
    logic en_pc;
    logic en_if_id;
    logic en_id_ex;
    logic en_ex_mem;
    logic en_mem_wb;
    logic flush_if_id;
    logic flush_id_ex;
    logic flush_ex_mem;
  } stage_ctrl_t;

  localparam stage_ctrl_t CTRL_RUN = '{
    en_pc: 1'b1, en_if_id: 1'b1, en_id_ex: 1'b1, en_ex_mem: 1'b1, en_mem_wb: 1'b1,
    flush_if_id: 1'b0, flush_id_ex: 1'b0, flush_ex_mem: 1'b0
  };

  localparam stage_ctrl_t CTRL_FREEZE = '{
    en_pc: 1'b0, en_if_id: 1'b0, en_id_ex: 1'b0, en_ex_mem: 1'b0, en_mem_wb: 1'b0,
    flush_if_id: 1'b0, flush_id_ex: 1'b0, flush_ex_mem: 1'b0
  };

  // A taken branch squashes any load-use stall since the ID instruction is wrong-path.
  function automatic stage_ctrl_t run_ctrl(input logic branch, input logic hazard);
    stage_ctrl_t c;
    c = CTRL_RUN;
    if (branch) begin
      c.flush_if_id = 1'b1;
      c.flush_id_ex = 1'b1;
    end else if (hazard) begin
      c.en_pc       = 1'b0;
      c.en_if_id    = 1'b0;
      c.flush_id_ex = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - combinational load-use hazard compare between ID sources and EX load
module load_use_detect #(
  parameter int ADDR_W = 3
) (
  input  logic [ADDR_W-1:0] i_id_rs,
  input  logic [ADDR_W-1:0] i_id_rt,
  input  logic              i_id_uses_rs,
  input  logic              i_id_uses_rt,
  input  logic              i_ex_mem_read,
  input  logic [ADDR_W-1:0] i_ex_rd,
  output logic              o_hazard
);

  logic w_rs_match;
  logic w_rt_match;

  assign w_rs_match = i_id_uses_rs & (i_id_rs == i_ex_rd);
  assign w_rt_match = i_id_uses_rt & (i_id_rt == i_ex_rd);
  assign o_hazard   = i_ex_mem_read & (w_rs_match | w_rt_match);

endmodule

// File: rtl/pipeline_hazard_controller.sv
// rtl/pipeline_hazard_controller.sv - stage enable/flush sequencer for the 5-stage pipeline
module pipeline_hazard_controller #(
  parameter int REG_ADDR_W   = pipeline_ctrl_pkg::REG_ADDR_W,
  parameter int DRAIN_CYCLES = 3,
  parameter int MEM_TIMEOUT  = 15,
  parameter int CNT_W        = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_branch_taken,
  input  logic                  mem_req,
  input  logic                  mem_ack,
  input  logic                  int_req,
  input  logic                  stall_clr,
  output logic                  en_pc,
  output logic                  en_if_id,
  output logic                  en_id_ex,
  output logic                  en_ex_mem,
  output logic                  en_mem_wb,
  output logic                  flush_if_id,
  output logic                  flush_id_ex,
  output logic                  flush_ex_mem,
  output logic                  int_ack,
  output logic                  mem_err,
  output logic [CNT_W-1:0]      stall_cnt
);
  import pipeline_ctrl_pkg::*;

  localparam int WAIT_W  = $clog2(MEM_TIMEOUT + 1);
  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  state_t            r_state, w_state_nxt;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [DRAIN_W-1:0] r_drain_cnt, w_drain_nxt;
  logic              r_int_pending, w_int_pending_nxt;
  logic              r_int_gap, w_int_gap_nxt;
  logic              r_mem_err;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic              w_hazard;
  logic              w_mem_stall;
  logic              w_int_ack;
  stage_ctrl_t       w_ctrl;

  load_use_detect #(.ADDR_W(REG_ADDR_W)) u_load_use (
    .i_id_rs      (id_rs),
    .i_id_rt      (id_rt),
    .i_id_uses_rs (id_uses_rs),
    .i_id_uses_rt (id_uses_rt),
    .i_ex_mem_read(ex_mem_read),
    .i_ex_rd      (ex_rd),
    .o_hazard     (w_hazard)
  );

  // Once in MEM_WAIT only the ack releases the freeze, so mem_req is not re-qualified there.
  assign w_mem_stall = (r_state == MEM_WAIT) ? ~mem_ack : (mem_req & ~mem_ack);

  always_comb begin
    w_ctrl            = CTRL_RUN;
    w_int_ack         = 1'b0;
    w_state_nxt       = r_state;
    w_drain_nxt       = r_drain_cnt;
    w_int_pending_nxt = r_int_pending;
    w_int_gap_nxt     = r_int_gap;
    if (RST) begin
      case (r_state)
        RUN: begin
          w_int_gap_nxt = 1'b0;
          if (w_mem_stall) begin
            w_ctrl      = CTRL_FREEZE;
            w_state_nxt = MEM_WAIT;
          end else if (ex_branch_taken || w_hazard) begin
            w_ctrl = run_ctrl(ex_branch_taken, w_hazard);
          end else if (int_req && !r_int_gap) begin
            w_int_pending_nxt = 1'b1;
            w_drain_nxt       = '0;
            w_state_nxt       = INT_DRAIN;
          end
        end
        MEM_WAIT: begin
          if (w_mem_stall) begin
            w_ctrl = CTRL_FREEZE;
          end else begin
            w_ctrl      = run_ctrl(ex_branch_taken, w_hazard);
            w_state_nxt = RUN;
          end
        end
        INT_DRAIN: begin
          if (w_mem_stall) begin
            w_ctrl = CTRL_FREEZE;
          end else begin
            w_ctrl = run_ctrl(ex_branch_taken, w_hazard);
            // A branch keeps en_pc so the redirect target becomes the saved return PC.
            if (!ex_branch_taken && !w_hazard) begin
              w_ctrl.en_pc       = 1'b0;
              w_ctrl.flush_if_id = 1'b1;
            end
            if (r_drain_cnt == DRAIN_W'(DRAIN_CYCLES - 1)) begin
              w_state_nxt = INT_ACK;
            end else begin
              w_drain_nxt = r_drain_cnt + DRAIN_W'(1);
            end
          end
        end
        INT_ACK: begin
          if (w_mem_stall) begin
            w_ctrl = CTRL_FREEZE;
          end else begin
            w_ctrl.flush_if_id = 1'b1;
            w_int_ack          = r_int_pending;
            w_int_pending_nxt  = 1'b0;
            w_int_gap_nxt      = 1'b1;
            w_state_nxt        = RUN;
          end
        end
        default: w_state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state       <= RUN;
      r_wait_cnt    <= '0;
      r_drain_cnt   <= '0;
      r_int_pending <= 1'b0;
      r_int_gap     <= 1'b0;
      r_mem_err     <= 1'b0;
      r_stall_cnt   <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_drain_cnt   <= w_drain_nxt;
      r_int_pending <= w_int_pending_nxt;
      r_int_gap     <= w_int_gap_nxt;
      if (!w_mem_stall) begin
        r_wait_cnt <= '0;
      end else if (r_wait_cnt != WAIT_W'(MEM_TIMEOUT)) begin
        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
      end
      if (w_mem_stall && r_wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
        r_mem_err <= 1'b1;
      end
      if (stall_clr) begin
        r_stall_cnt <= '0;
      end else if (!w_ctrl.en_pc && r_stall_cnt != {CNT_W{1'b1}}) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

  assign en_pc        = w_ctrl.en_pc;
  assign en_if_id     = w_ctrl.en_if_id;
  assign en_id_ex     = w_ctrl.en_id_ex;
  assign en_ex_mem    = w_ctrl.en_ex_mem;
  assign en_mem_wb    = w_ctrl.en_mem_wb;
  assign flush_if_id  = w_ctrl.flush_if_id;
  assign flush_id_ex  = w_ctrl.flush_id_ex;
  assign flush_ex_mem = w_ctrl.flush_ex_mem;
  assign int_ack      = w_int_ack;
  assign mem_err      = r_mem_err;
  assign stall_cnt    = r_stall_cnt;

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Central sequencer for the 5-stage pipeline's stage registers (PC, IF/ID, ID/EX, EX/MEM, MEM/WB).
- Generates per-stage enable and flush strobes that resolve four conditions: load-use hazards, taken branches, multi-cycle data-memory waits, and external interrupt entry.
- Also keeps a saturating stall-cycle counter and a sticky memory-timeout error flag.
- Sits beside the hazard-detect logic in ID and drives the EN inputs of every stage register.

Parameters:
- REG_ADDR_W, 3, register-file address width.
- DRAIN_CYCLES, 3, cycles fetch is held off before the interrupt vector load.
- MEM_TIMEOUT, 15, maximum consecutive memory-wait cycles before mem_err is raised.
- CNT_W, 16, stall counter width.

Ports:
- CLK  in  1  rising-edge clock.
- RST  in  1  asynchronous active-low reset.
- id_rs  in  REG_ADDR_W  ID source register A.
- id_rt  in  REG_ADDR_W  ID source register B.
- id_uses_rs  in  1  ID instruction reads rs.
- id_uses_rt  in  1  ID instruction reads rt.
- ex_mem_read  in  1  EX instruction is a load.
- ex_rd  in  REG_ADDR_W  EX destination register.
- ex_branch_taken  in  1  branch resolved taken in EX.
- mem_req  in  1  MEM stage access in progress.
- mem_ack  in  1  memory completes the access this cycle.
- int_req  in  1  external interrupt, level.
- stall_clr  in  1  synchronous clear of stall_cnt.
- en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb  out  1 each  stage register enables.
- flush_if_id, flush_id_ex, flush_ex_mem  out  1 each  synchronous bubble insert; overrides en in the stage register.
- int_ack  out  1  one-cycle pulse: load interrupt vector into PC, save return PC.
- mem_err  out  1  sticky memory-timeout flag.
- stall_cnt  out  CNT_W  cycles in which en_pc=0.

Behaviour:
- Reset (RST=0, asynchronous):
  - state=RUN, stall_cnt=0, mem_err=0, int_pending=0, counters=0.
  - Outputs forced to: all en=1, all flush=0, int_ack=0.
- Output style: Mealy. Outputs are combinational from the registered state plus current inputs. State, counters and flags update on the rising CLK edge.
- Per-cycle priority, highest first: memory wait > branch flush > load-use > interrupt entry.
- RUN:
  - Memory wait: mem_req=1 and mem_ack=0 → all en=0, no flush; go to MEM_WAIT; wait_cnt=1.
  - Taken branch: ex_branch_taken=1 → all en=1, flush_if_id=1, flush_id_ex=1. Any coincident load-use is ignored because that instruction is wrong-path.
  - Load-use: hazard = ex_mem_read & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd)). When set: en_pc=0, en_if_id=0, flush_id_ex=1, other en=1. Lasts exactly one cycle; state stays RUN.
  - Interrupt entry: int_req=1 with none of the above → int_pending=1, go to INT_DRAIN with drain_cnt=0.
- MEM_WAIT:
  - All en=0 every cycle; wait_cnt increments.
  - When wait_cnt reaches MEM_TIMEOUT, mem_err is set and stays set until reset.
  - mem_ack=1 → normal RUN outputs are evaluated that same cycle (the pipeline advances), then next state is RUN.
- INT_DRAIN:
  - en_pc=0, flush_if_id=1, other en=1; drain_cnt increments.
  - A memory wait in this state freezes everything (all en=0) and holds drain_cnt.
  - Branch flushes during drain are still honoured.
  - When drain_cnt reaches DRAIN_CYCLES-1 → INT_ACK.
- INT_ACK:
  - One cycle: int_ack=1, en_pc=1, flush_if_id=1.
  - int_pending cleared; next state RUN.
  - int_req still high → new entry is allowed only after one RUN cycle.
- Further interrupts: int_req during INT_DRAIN/INT_ACK is ignored; there is no nesting.
- stall_cnt:
  - Increments when en_pc=0; saturates at all-ones.
  - stall_clr has priority over increment.
- flush implies the target stage is enabled; en=0 together with flush=1 is never driven.

Decomposition:
- Shared package pipeline_ctrl_pkg holds:
  - state enum {RUN, MEM_WAIT, INT_DRAIN, INT_ACK};
  - REG_ADDR_W;
  - a stage-control bundle type (en/flush bits per stage).
- One sub-module, load_use_detect: the combinational hazard compare, reusable by the forwarding unit.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=3, id_rs=3, id_uses_rs=1 → one cycle with en_pc=0, en_if_id=0, flush_id_ex=1; next cycle all en=1; stall_cnt=1.
- Branch over hazard: ex_branch_taken=1 with the same load-use inputs → flush_if_id=1, flush_id_ex=1, en_pc=1; stall_cnt unchanged.
- Memory wait: mem_req=1 with mem_ack low for 4 cycles → all en=0 for 4 cycles; on the 5th cycle mem_ack=1 and all en=1; stall_cnt=4; mem_err=0.
- Memory timeout: mem_req=1 with mem_ack low for 20 cycles → mem_err=1 from cycle 15 and stays 1 after ack; only RST=0 clears it.
- Interrupt: int_req pulse in idle RUN → 3 cycles of en_pc=0/flush_if_id=1, then int_ack=1 for exactly 1 cycle, then RUN. Repeat with a 2-cycle memory wait mid-drain → int_ack delayed by 2 cycles.
- Async reset: assert RST=0 mid-INT_DRAIN, between clock edges → outputs go to reset values immediately; int_ack never pulses; stall_cnt=0.
